// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, special register ids and data width.
package y86_pkg;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned NREGS = 15;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/regfile_15x64.sv
// 15-entry register file: two combinational read ports, two write ports (M beats E),
// asynchronous active-high clear. Id 0xF has no storage and reads as zero.
module regfile_15x64
  import y86_pkg::*;
#(
  parameter int unsigned Width = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src_a,
  input  logic [3:0]       src_b,
  output logic [Width-1:0] rd_a,
  output logic [Width-1:0] rd_b,
  input  logic             we_e,
  input  logic [3:0]       dst_e,
  input  logic [Width-1:0] wd_e,
  input  logic             we_m,
  input  logic [3:0]       dst_m,
  input  logic [Width-1:0] wd_m
);

  logic [Width-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        // popq %rsp makes both ports target one entry; the loaded value wins
        if (we_m && dst_m == 4'(i)) begin
          regs_q[i] <= wd_m;
        end else if (we_e && dst_e == 4'(i)) begin
          regs_q[i] <= wd_e;
        end
      end
    end
  end

  assign rd_a = (src_a == RNONE) ? '0 : regs_q[src_a];
  assign rd_b = (src_b == RNONE) ? '0 : regs_q[src_b];

endmodule

// File: rtl/decode_writeback.sv
// SEQ decode/write-back stage: register-id decode plus the register file.
// Define DECODE_BYPASS_EN to forward this cycle's valE/valM onto valA/valB.
module decode_writeback
  import y86_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cnd,
  input  logic [WIDTH-1:0] valE,
  input  logic [WIDTH-1:0] valM,
  input  logic             wb_en,
  output logic [3:0]       srcA,
  output logic [3:0]       srcB,
  output logic [3:0]       dstE,
  output logic [3:0]       dstM,
  output logic [WIDTH-1:0] valA,
  output logic [WIDTH-1:0] valB
);

  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             we_e;
  logic             we_m;

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (icode)
      IRRMOVQ: begin
        srcA = rA;
        dstE = cnd ? rB : RNONE;
      end
      IIRMOVQ: dstE = rB;
      IRMMOVQ: begin
        srcA = rA;
        srcB = rB;
      end
      IMRMOVQ: begin
        srcB = rB;
        dstM = rA;
      end
      IOPQ: begin
        srcA = rA;
        srcB = rB;
        dstE = rB;
      end
      ICALL: begin
        srcB = RRSP;
        dstE = RRSP;
      end
      IRET: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
      end
      IPUSHQ: begin
        srcA = rA;
        srcB = RRSP;
        dstE = RRSP;
      end
      IPOPQ: begin
        srcA = RRSP;
        srcB = RRSP;
        dstE = RRSP;
        dstM = rA;
      end
      default: ;
    endcase
  end

  assign we_e = wb_en && (dstE != RNONE);
  assign we_m = wb_en && (dstM != RNONE);

  regfile_15x64 #(
    .Width(WIDTH)
  ) u_regfile (
    .clk  (clk),
    .rst  (rst),
    .src_a(srcA),
    .src_b(srcB),
    .rd_a (rd_a),
    .rd_b (rd_b),
    .we_e (we_e),
    .dst_e(dstE),
    .wd_e (valE),
    .we_m (we_m),
    .dst_m(dstM),
    .wd_m (valM)
  );

`ifdef DECODE_BYPASS_EN
  // Write-through: a read of an id being written this cycle sees the new value
  always_comb begin
    valA = rd_a;
    valB = rd_b;
    if (!rst && srcA != RNONE) begin
      if (we_m && srcA == dstM) begin
        valA = valM;
      end else if (we_e && srcA == dstE) begin
        valA = valE;
      end
    end
    if (!rst && srcB != RNONE) begin
      if (we_m && srcB == dstM) begin
        valB = valM;
      end else if (we_e && srcB == dstE) begin
        valB = valE;
      end
    end
  end
`else
  assign valA = rd_a;
  assign valB = rd_b;
`endif

endmodule

// File: doc/decode_writeback.md
Name: decode_writeback

Overview:
- SEQ decode and write-back stage, directly downstream of fetch.
- Consumes icode/rA/rB from fetch and holds the 15-entry Y86-64 register file.
- Produces valA/valB combinationally for execute; commits valE/valM on the rising clock edge at the end of the instruction cycle.

Parameters:
- WIDTH, 64, data width of each register and of valA/valB/valE/valM.
- NREGS, 15, number of architectural registers (ids 0x0-0xE).
- RSP_ID, 4'h4, register id of %rsp.
- RNONE, 4'hF, "no register" id.

Ports:
- clk  input  1  system clock; all register-file writes occur on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- icode  input  4  instruction code from fetch.
- rA  input  4  register specifier A from fetch.
- rB  input  4  register specifier B from fetch.
- cnd  input  1  condition result from execute; gates cmovXX.
- valE  input  WIDTH  ALU result from execute.
- valM  input  WIDTH  memory read data.
- wb_en  input  1  global write enable; low on halt or any error status.
- srcA  output  4  decoded source A id.
- srcB  output  4  decoded source B id.
- dstE  output  4  decoded E destination id.
- dstM  output  4  decoded M destination id.
- valA  output  WIDTH  value of register srcA, or 0 if srcA==RNONE.
- valB  output  WIDTH  value of register srcB, or 0 if srcB==RNONE.

Behaviour:
- Reset: rst high asynchronously clears all NREGS registers to 0, so valA=valB=0 while in reset. srcA/srcB/dstE/dstM remain pure decode of their inputs.
- srcA:
  - rA for icode 2, 4, 6, A.
  - RSP_ID for 9, B.
  - otherwise RNONE.
- srcB:
  - rB for 4, 5, 6.
  - RSP_ID for 8, 9, A, B.
  - otherwise RNONE.
- dstE:
  - rB for 3 and 6.
  - rB for 2 only when cnd=1 (ifun 0 is driven with cnd=1 by execute); RNONE when cnd=0.
  - RSP_ID for 8, 9, A, B.
  - otherwise RNONE.
- dstM: rA for 5 and B; otherwise RNONE.
- Reads: combinational, zero latency, reflecting register contents before the current edge.
- Writes: on rising clk with wb_en=1 and rst=0:
  - reg[dstE] <= valE if dstE != RNONE.
  - reg[dstM] <= valM if dstM != RNONE.
- Collision: dstE==dstM (popq %rsp) writes valM only; valE is discarded.
- Write to id RNONE: always ignored; no storage exists for id 0xF.
- Read of id RNONE: returns 0.
- wb_en=0: the register file is frozen for that edge.
- Reset asserted mid-cycle: clears immediately regardless of a pending write; the first write after deassertion occurs on the next rising edge.
- Undefined icode (>0xB): all four ids are RNONE and no write occurs.

Optional Feature:
- Macro: DECODE_BYPASS_EN.
- Defined: write-through forwarding. If srcA (or srcB) equals a dstE/dstM being written this cycle with wb_en=1, valA (valB) returns the incoming valE/valM, with valM taking priority. Intended for reuse by the PIPE variant.
- Undefined: reads always return stored contents; no forwarding logic is built.

Decomposition:
- Shared package y86_pkg:
  - icode constants: IHALT, INOP, IRRMOVQ, IIRMOVQ, IRMMOVQ, IMRMOVQ, IOPQ, IJXX, ICALL, IRET, IPUSHQ, IPOPQ.
  - RRSP, RNONE.
  - WIDTH.
- Sub-module regfile_15x64: the two read ports plus two write ports with priority and async reset.
- Decode mux logic stays in decode_writeback.

Test Plan:
- Reset: assert rst, then icode=6 rA=0 rB=1 -> valA=0, valB=0, srcA=0, srcB=1, dstE=1.
- irmovq: icode=3 rB=2 valE=0x64 wb_en=1, one edge; then icode=6 rA=2 -> valA=0x64. dstM stays F throughout.
- cmov gating:
  - icode=2 rA=2 rB=3 cnd=0 valE=0x64 -> dstE=F and reg3 unchanged at 0.
  - cnd=1 -> reg3=0x64 after the edge.
- popq %rsp: icode=B rA=4 valE=0x108 valM=0xABC -> after the edge reg4=0xABC, not 0x108.
- wb_en=0: icode=3 rB=5 valE=0x55, edge -> reg5 remains 0. Separately, icode=3 rB=F -> no register changes.
- Async reset mid-cycle: load reg7=0x77, pulse rst between edges -> valA reads 0 immediately, without waiting for a clk edge.
